// File: rtl/line_beat_adapter.sv
// Serialises one cache-line read/write into BUS_WIDTH memory beats, one outstanding.
// Optional CRITICAL_WORD_FIRST_EN starts the beat sequence at the requested word.
module line_beat_adapter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int BUS_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      line_req_valid,
  output logic                      line_req_ready,
  input  logic [ADDRESS_WIDTH-1:0]  line_req_address,
  input  logic                      line_req_wen,
  input  logic [LINE_WIDTH-1:0]     line_req_data,
  input  logic [LINE_WIDTH/8-1:0]   line_req_strobe,
  output logic                      line_rsp_valid,
  output logic [LINE_WIDTH-1:0]     line_rsp_data,
  output logic                      mem_req_valid,
  output logic [ADDRESS_WIDTH-1:0]  mem_req_address,
  output logic [BUS_WIDTH-1:0]      mem_req_data,
  output logic [BUS_WIDTH/8-1:0]    mem_req_strobe,
  output logic                      mem_req_wen,
  input  logic                      mem_rsp_valid,
  input  logic [BUS_WIDTH-1:0]      mem_rsp_data
);

  localparam int AW    = ADDRESS_WIDTH;
  localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int BB    = BUS_WIDTH / 8;
  localparam int SW    = LINE_WIDTH / 8;
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int BOFF  = $clog2(BB);
  localparam int LOFF  = $clog2(SW);
  localparam int BSW   = AW - LOFF;

  localparam logic [CW-1:0] LAST = CW'(BEATS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         start_q, start_d;
  logic [BSW-1:0]        base_q, base_d;
  logic                  wen_q, wen_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;

  logic                  rsp_v_q, rsp_v_d;
  logic                  req_v_q, req_v_d;
  logic [AW-1:0]         req_a_q, req_a_d;
  logic [BUS_WIDTH-1:0]  req_dat_q, req_dat_d;
  logic [BB-1:0]         req_s_q, req_s_d;
  logic                  req_w_q, req_w_d;

  logic [IW-1:0]         start_in;
  logic [IW-1:0]         idx_q;
  logic [IW-1:0]         idx_d;
  logic                  unused_addr_lo;

  assign unused_addr_lo = ^line_req_address[LOFF-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_in = line_req_address[LOFF-1:BOFF];
`else
  assign start_in = '0;
`endif

  function automatic logic [IW-1:0] beat_idx(
    input logic [IW-1:0] st,
    input logic [CW-1:0] c
  );
    return IW'((int'(st) + int'(c)) % BEATS);
  endfunction

  // First count at or after 'from' whose beat must go on the bus;
  // empty write beats are skipped, LAST means nothing left.
  function automatic logic [CW-1:0] next_cnt(
    input int            from,
    input logic          wen,
    input logic [SW-1:0] strb,
    input logic [IW-1:0] st
  );
    logic [CW-1:0] r;
    logic [IW-1:0] k;
    r = LAST;
    for (int i = BEATS - 1; i >= 0; i--) begin
      k = beat_idx(st, CW'(i));
      if (i >= from && (!wen || (|strb[k*BB +: BB])))
        r = CW'(i);
    end
    return r;
  endfunction

  assign idx_q = beat_idx(start_q, cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    base_d  = base_q;
    wen_d   = wen_q;
    data_d  = data_q;
    strb_d  = strb_q;
    line_d  = line_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (line_req_valid) begin
          base_d  = line_req_address[AW-1:LOFF];
          wen_d   = line_req_wen;
          data_d  = line_req_data;
          strb_d  = line_req_strobe;
          start_d = start_in;
          cnt_d   = next_cnt(0, line_req_wen,
                             line_req_strobe, start_in);
          state_d = S_ISSUE;
        end
      end
      (state_q == S_ISSUE): begin
        state_d = (cnt_q == LAST) ? S_RESP : S_WAIT;
      end
      (state_q == S_WAIT): begin
        if (mem_rsp_valid) begin
          if (!wen_q)
            line_d[idx_q*BUS_WIDTH +: BUS_WIDTH] = mem_rsp_data;
          cnt_d   = next_cnt(int'(cnt_q) + 1, wen_q,
                             strb_q, start_q);
          state_d = S_ISSUE;
        end
      end
      (state_q == S_RESP): begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they line up
  // with the state they belong to.
  always_comb begin
    idx_d     = beat_idx(start_d, cnt_d);
    req_v_d   = (state_d == S_ISSUE) && (cnt_d != LAST);
    rsp_v_d   = (state_d == S_RESP);
    req_a_d   = '0;
    req_dat_d = '0;
    req_s_d   = '0;
    req_w_d   = 1'b0;
    if (req_v_d) begin
      req_a_d = {base_d, idx_d, {BOFF{1'b0}}};
      req_w_d = wen_d;
      if (wen_d) begin
        req_dat_d = data_d[idx_d*BUS_WIDTH +: BUS_WIDTH];
        req_s_d   = strb_d[idx_d*BB +: BB];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      start_q   <= '0;
      base_q    <= '0;
      wen_q     <= 1'b0;
      data_q    <= '0;
      strb_q    <= '0;
      line_q    <= '0;
      rsp_v_q   <= 1'b0;
      req_v_q   <= 1'b0;
      req_a_q   <= '0;
      req_dat_q <= '0;
      req_s_q   <= '0;
      req_w_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      base_q    <= base_d;
      wen_q     <= wen_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      line_q    <= line_d;
      rsp_v_q   <= rsp_v_d;
      req_v_q   <= req_v_d;
      req_a_q   <= req_a_d;
      req_dat_q <= req_dat_d;
      req_s_q   <= req_s_d;
      req_w_q   <= req_w_d;
    end
  end

  assign line_req_ready  = (state_q == S_IDLE);
  assign line_rsp_valid  = rsp_v_q;
  assign line_rsp_data   = line_q;
  assign mem_req_valid   = req_v_q;
  assign mem_req_address = req_a_q;
  assign mem_req_data    = req_dat_q;
  assign mem_req_strobe  = req_s_q;
  assign mem_req_wen     = req_w_q;

endmodule

// File: tb/tb_line_beat_adapter.sv
// Bench for line_beat_adapter: directed cases plus random line traffic
// against a word-addressed memory model and a beat-list reference.
module tb_line_beat_adapter;

  localparam int LW = 128;
  localparam int BW = 32;
  localparam int NB = LW / BW;
  localparam int BB = BW / 8;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        w;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          line_req_valid;
  logic          line_req_ready;
  logic [31:0]   line_req_address;
  logic          line_req_wen;
  logic [LW-1:0] line_req_data;
  logic [15:0]   line_req_strobe;
  logic          line_rsp_valid;
  logic [LW-1:0] line_rsp_data;
  logic          mem_req_valid;
  logic [31:0]   mem_req_address;
  logic [31:0]   mem_req_data;
  logic [3:0]    mem_req_strobe;
  logic          mem_req_wen;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;

  line_beat_adapter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .line_req_valid   (line_req_valid),
    .line_req_ready   (line_req_ready),
    .line_req_address (line_req_address),
    .line_req_wen     (line_req_wen),
    .line_req_data    (line_req_data),
    .line_req_strobe  (line_req_strobe),
    .line_rsp_valid   (line_rsp_valid),
    .line_rsp_data    (line_rsp_data),
    .mem_req_valid    (mem_req_valid),
    .mem_req_address  (mem_req_address),
    .mem_req_data     (mem_req_data),
    .mem_req_strobe   (mem_req_strobe),
    .mem_req_wen      (mem_req_wen),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [bit [31:0]];
  beat_t       log_q[$];
  bit          inject = 0;
  bit          rsp_en = 1;
  int          dly = 1;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [LW-1:0] last_line = '0;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Memory port model: answers each beat dly cycles after its request.
  initial begin
    int          cd;
    logic [31:0] cur_a;
    logic [31:0] w;
    beat_t       b;
    cd = 0;
    cur_a = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (inject) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hDEAD_BEEF;
        inject = 0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data = mrd(cur_a);
        end
      end
      if (mem_req_valid === 1'b1) begin
        b.a = mem_req_address;
        b.d = mem_req_data;
        b.s = mem_req_strobe;
        b.w = mem_req_wen;
        log_q.push_back(b);
        cur_a = mem_req_address;
        if (mem_req_wen) begin
          w = mrd(cur_a);
          for (int j = 0; j < BB; j++)
            if (mem_req_strobe[j]) w[j*8 +: 8] = mem_req_data[j*8 +: 8];
          mem[cur_a] = w;
        end
        if (rsp_en) cd = dly;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_line(input logic [31:0] a, input logic wen,
                          input logic [LW-1:0] data, input logic [15:0] strb,
                          input int d, input string tag);
    beat_t         exp_q[$];
    beat_t         e;
    logic [LW-1:0] exp_line;
    logic [31:0]   base;
    int            st;
    int            k;
    int            acc;
    int            nb;
    bit            seen;
    base = a & ~32'hF;
    st = 0;
`ifdef CRITICAL_WORD_FIRST_EN
    st = int'((a >> 2) % NB);
`endif
    for (int c = 0; c < NB; c++) begin
      k = (st + c) % NB;
      if (!wen || strb[k*BB +: BB] != 0) begin
        e.a = base + 32'(k * BB);
        e.d = data[k*BW +: BW];
        e.s = strb[k*BB +: BB];
        e.w = wen;
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < NB; i++) exp_line[i*BW +: BW] = mrd(base + 32'(i * BB));
    dly = d;
    log_q.delete();
    check({tag, " ready"}, LW'(line_req_ready), LW'(1));
    line_req_valid = 1'b1;
    line_req_address = a;
    line_req_wen = wen;
    line_req_data = data;
    line_req_strobe = strb;
    acc = int'(cyc);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      if (i == 0) line_req_valid = 1'b0;
      if (line_rsp_valid === 1'b1) seen = 1;
    end
    check({tag, " rsp seen"}, LW'(seen), LW'(1));
    check({tag, " latency"}, LW'(int'(cyc) - acc),
          LW'(exp_q.size() * (d + 1) + 2));
    check({tag, " ready in resp"}, LW'(line_req_ready), LW'(0));
    if (!wen) last_line = exp_line;
    check({tag, " line data"}, line_rsp_data, last_line);
    nb = log_q.size();
    check({tag, " beat count"}, LW'(nb), LW'(exp_q.size()));
    for (int i = 0; i < nb && i < exp_q.size(); i++) begin
      check({tag, " beat addr"}, LW'(log_q[i].a), LW'(exp_q[i].a));
      check({tag, " beat wen"}, LW'(log_q[i].w), LW'(exp_q[i].w));
      if (wen) begin
        check({tag, " beat data"}, LW'(log_q[i].d), LW'(exp_q[i].d));
        check({tag, " beat strb"}, LW'(log_q[i].s), LW'(exp_q[i].s));
      end
    end
    step();
    check({tag, " rsp pulse end"}, LW'(line_rsp_valid), LW'(0));
    check({tag, " ready again"}, LW'(line_req_ready), LW'(1));
  endtask

  initial begin
    logic [31:0]   a;
    logic          w;
    logic [LW-1:0] dat;
    logic [15:0]   s;
    bit            hit;
    rst_n = 1'b0;
    line_req_valid = 1'b0;
    line_req_address = '0;
    line_req_wen = 1'b0;
    line_req_data = '0;
    line_req_strobe = '0;
    repeat (3) step();
    check("rst ready", LW'(line_req_ready), LW'(1));
    check("rst req_valid", LW'(mem_req_valid), LW'(0));
    check("rst rsp_valid", LW'(line_rsp_valid), LW'(0));
    check("rst rsp_data", line_rsp_data, '0);
    check("rst req_addr", LW'(mem_req_address), LW'(0));
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NB; i++) mem[32'h1000 + 32'(i * 4)] = 32'hA0 + 32'(i);
    run_line(32'h0000_1008, 1'b0, '0, '0, 4, "rd1008");
    check("rd1008 line", line_rsp_data,
          {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    run_line(32'h0000_2000, 1'b1, {32'h4444_4444, 32'h3333_3333,
             32'h2222_2222, 32'h1111_1111}, 16'h0F0F, 2, "wr0f0f");
    run_line(32'h0000_2004, 1'b1, {4{32'hFFFF_FFFF}}, 16'h0000, 3, "wrzero");

    inject = 1;
    hit = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_req_valid !== 1'b0 || line_rsp_valid !== 1'b0) hit = 1;
    end
    check("stray idle quiet", LW'(hit), LW'(0));
    run_line(32'h0000_100C, 1'b0, '0, '0, 1, "stray rd");
    check("stray rd line", line_rsp_data,
          {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    rsp_en = 0;
    dly = 3;
    log_q.delete();
    line_req_valid = 1'b1;
    line_req_address = 32'h0000_4004;
    line_req_wen = 1'b0;
    step();
    line_req_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step();
      if (log_q.size() >= 1) hit = 1;
    end
    check("rstmid first beat", LW'(hit), LW'(1));
    // Hand-feed two acks so the adapter reaches WAIT of beat 2.
    for (int b = 0; b < 2; b++) begin
      inject = 1;
      step();
      step();
      step();
    end
    check("rstmid beats", LW'(log_q.size()), LW'(3));
    rst_n = 1'b0;
    #1;
    check("rstmid ready", LW'(line_req_ready), LW'(1));
    check("rstmid req_valid", LW'(mem_req_valid), LW'(0));
    check("rstmid req_addr", LW'(mem_req_address), LW'(0));
    check("rstmid rsp_valid", LW'(line_rsp_valid), LW'(0));
    check("rstmid rsp_data", line_rsp_data, '0);
    step();
    rst_n = 1'b1;
    last_line = '0;
    inject = 1;
    hit = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mem_req_valid !== 1'b0 || line_rsp_valid !== 1'b0 ||
          line_req_ready !== 1'b1) hit = 1;
    end
    check("late rsp ignored", LW'(hit), LW'(0));
    rsp_en = 1;
    run_line(32'h0000_1004, 1'b0, '0, '0, 2, "post rst rd");

    for (int n = 0; n < 16; n++) begin
      a = 32'h3000 + 32'($urandom_range(0, 7) << 4) + 32'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      dat = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: s = 16'h0000;
        1: s = 16'hFFFF;
        default: s = 16'($urandom);
      endcase
      run_line(a, w, dat, s, int'($urandom_range(1, 5)), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
